// File: rtl/rom_reader.sv
// Block-read master for a 16x4 synchronous ROM, streaming words on a valid/ready port.
// Optional running XOR checksum output enabled by defining ROM_READER_CKSUM_EN.
module rom_reader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef ROM_READER_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t          state;
  logic [ADDR_W:0] remaining;

  // rom_addr doubles as the current block address; every output is set on entry to its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_addr  <= '0;
      rom_cs    <= 1'b0;
      rom_rd    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef ROM_READER_CKSUM_EN
      cksum     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr  <= base_addr;
            remaining <= len;
            busy      <= 1'b1;
`ifdef ROM_READER_CKSUM_EN
            cksum     <= '0;
`endif
            if (len != '0) begin
              state  <= ISSUE;
              rom_cs <= 1'b1;
              rom_rd <= 1'b1;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state  <= CAPTURE;
          rom_rd <= 1'b0;
        end
        CAPTURE: begin
          state     <= HOLD;
          out_data  <= rom_data;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rom_addr  <= rom_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
`ifdef ROM_READER_CKSUM_EN
            cksum     <= cksum ^ out_data;
`endif
            if (remaining == (ADDR_W+1)'(1)) begin
              state  <= FINISH;
              rom_cs <= 1'b0;
              done   <= 1'b1;
            end else begin
              state  <= ISSUE;
              rom_rd <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          rom_cs <= 1'b0;
          rom_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: ROM model rom[a]=15-a, table-driven blocks plus randomized blocks.
// Define ROM_READER_CKSUM_EN for both files to exercise the checksum port.
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] len;
  logic       busy, done, rom_cs, rom_rd, out_valid, out_ready;
  logic [3:0] rom_addr, rom_data, out_data;
`ifdef ROM_READER_CKSUM_EN
  logic [3:0] cksum;
`endif

  int n_pass = 0;
  int n_total = 0;

  rom_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_rd(rom_rd),
`ifdef ROM_READER_CKSUM_EN
    .cksum(cksum),
`endif
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: registers rom[addr] on a read, otherwise holds its output.
  logic [3:0] rom_q = 4'h0;
  always @(posedge clk) if (rom_cs && rom_rd) rom_q <= 4'(15 - int'(rom_addr));
  assign rom_data = rom_q;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  typedef struct {
    int         b;
    int         l;
    int         mode;   // 0: ready always, 1: stall word sk for sn cycles, 2: random ready
    int         sk;
    int         sn;
    bit         inj;    // pulse start during HOLD of word 1
    logic [3:0] exp_first;
    logic [3:0] exp_last;
    logic [3:0] exp_ck;
  } vec_t;

  // Runs one block starting at a negedge; the model is the list of words 15-((b+i) mod 16).
  task automatic run_block(input int b, input int l, input int mode, input int sk,
                           input int sn, input bit inj,
                           output logic [3:0] fw, output logic [3:0] lw, output logic [3:0] ck_seen);
    logic [3:0] exp_q[$];
    logic [3:0] ck = 4'h0;
    int idx = 0, cyc = 0, first_v = -1, last_t = -1, dones = 0, done_cyc = -1;
    int rds = 0, held = 0;
    bit gap_ok = 1'b1, ended = 1'b0, r;
    fw = 4'h0; lw = 4'h0; ck_seen = 4'h0;
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(4'(15 - ((b + i) % 16)));
      ck ^= 4'(15 - ((b + i) % 16));
    end
    @(negedge clk);
    start = 1'b1; base_addr = 4'(b); len = 5'(l); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!ended && cyc < 300) begin
      cyc++;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_after_done", busy, 0);
        ended = 1'b1;
      end else begin
        if (rom_rd) begin
          rds++;
          chk("rom_addr", rom_addr, (b + idx) % 16);
        end
        if (done) begin
          dones++;
          done_cyc = cyc;
`ifdef ROM_READER_CKSUM_EN
          chk("cksum_done", cksum, ck);
          ck_seen = cksum;
`endif
        end
        if (out_valid) begin
          if (first_v < 0) first_v = cyc;
          if (idx < exp_q.size()) chk("out_data", out_data, exp_q[idx]);
          else chk("extra_word", idx, exp_q.size() - 1);
          case (mode)
            0: r = 1'b1;
            1: begin
              r = (idx != sk) || (held >= sn);
              if (idx == sk) held++;
            end
            default: r = ($urandom_range(0, 3) != 0);
          endcase
          out_ready = r;
          start = inj && (idx == 1);
          if (r) begin
            if (idx == 0) fw = out_data;
            lw = out_data;
            if (last_t >= 0 && cyc - last_t != 3) gap_ok = 1'b0;
            last_t = cyc;
            idx++;
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (!ended) chk("timeout", 0, 1);
    chk("word_count", idx, l);
    chk("done_pulses", dones, 1);
    chk("rom_rd_pulses", rds, l);
    if (l > 0) begin
      chk("first_valid_cycle", first_v, 3);
      chk("done_after_last", done_cyc, last_t + 1);
      if (mode == 0) chk("word_spacing", int'(gap_ok), 1);
    end else begin
      chk("len0_done_cycle", done_cyc, 1);
      chk("len0_no_valid", first_v, -1);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {busy, done, rom_cs, rom_rd, out_valid, rom_addr, out_data}, 0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [3:0] fw, lw, cks;
    int b, l;
    rst = 1'b1; start = 1'b0; base_addr = 4'h0; len = 5'h0; out_ready = 1'b0;
    vecs.push_back('{b:0,  l:4,  mode:0, sk:0, sn:0, inj:1'b0, exp_first:4'hF, exp_last:4'hC, exp_ck:4'h0});
    vecs.push_back('{b:14, l:4,  mode:0, sk:0, sn:0, inj:1'b0, exp_first:4'h1, exp_last:4'hE, exp_ck:4'h0});
    vecs.push_back('{b:5,  l:3,  mode:1, sk:1, sn:5, inj:1'b0, exp_first:4'hA, exp_last:4'h8, exp_ck:4'hB});
    vecs.push_back('{b:3,  l:16, mode:0, sk:0, sn:0, inj:1'b0, exp_first:4'hC, exp_last:4'hD, exp_ck:4'h0});
    vecs.push_back('{b:0,  l:4,  mode:0, sk:0, sn:0, inj:1'b1, exp_first:4'hF, exp_last:4'hC, exp_ck:4'h0});
    vecs.push_back('{b:9,  l:1,  mode:0, sk:0, sn:0, inj:1'b0, exp_first:4'h6, exp_last:4'h6, exp_ck:4'h6});
    vecs.push_back('{b:7,  l:0,  mode:0, sk:0, sn:0, inj:1'b0, exp_first:4'h0, exp_last:4'h0, exp_ck:4'h0});

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_state");
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_block(vecs[i].b, vecs[i].l, vecs[i].mode, vecs[i].sk, vecs[i].sn, vecs[i].inj, fw, lw, cks);
      if (vecs[i].l > 0) begin
        chk($sformatf("vec%0d_first", i), fw, vecs[i].exp_first);
        chk($sformatf("vec%0d_last", i), lw, vecs[i].exp_last);
      end
`ifdef ROM_READER_CKSUM_EN
      chk($sformatf("vec%0d_cksum", i), cks, vecs[i].exp_ck);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_cksum_held", i), cksum, vecs[i].exp_ck);
`endif
    end

    // Reset in the middle of a block discards it without a done pulse.
    @(negedge clk);
    start = 1'b1; base_addr = 4'h0; len = 5'd4; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_block_reset");
`ifdef ROM_READER_CKSUM_EN
    chk("reset_cksum", cksum, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {busy, done, out_valid}, 0);
    end
    run_block(0, 1, 0, 0, 0, 1'b0, fw, lw, cks);
    chk("post_reset_word", fw, 4'hF);

    // Randomized blocks against the address-arithmetic model.
    for (int k = 0; k < 20; k++) begin
      b = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 16));
      run_block(b, l, 2, 0, 0, 1'($urandom_range(0, 1)), fw, lw, cks);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
